// File: rtl/disp_pkg.sv
// Shared types, segment lookup and polarity helper for the multiplexed hex display driver.
package disp_pkg;

   typedef struct packed {
      logic       dp;
      logic [3:0] val;
   } digit_t;

   // Bit 0 = segment a ... bit 6 = segment g, active-high; entry 15 first.
   localparam logic [15:0][6:0] SEG7 = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [31:0] apply_pol(logic [31:0] v, logic act_low);
      return act_low ? ~v : v;
   endfunction

endpackage

// File: rtl/hex7seg_m.sv
// Combinational nibble + decimal point to segment-bus decoder (dp on the MSB, active-high).
module hex7seg_m
   import disp_pkg::*;
#(
   parameter int unsigned SEG_W = 8
) (
   input  logic [3:0]       i_val,
   input  logic             i_dp,
   output logic [SEG_W-1:0] o_seg
);

   always_comb begin
      o_seg          = '0;
      o_seg[6:0]     = SEG7[i_val];
      o_seg[SEG_W-1] = i_dp;
   end

endmodule

// File: rtl/disp_scan_m.sv
// Multiplexed hex display driver: double-buffered digit RAM, frame-end commit, LZ blanking, PWM.
// Optional lamp test port and logic enabled by defining DISP_LAMP_TEST_EN.
module disp_scan_m
   import disp_pkg::*;
#(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned SEG_W       = 8,
   parameter int unsigned SCAN_DIV    = 1000,
   parameter int unsigned GUARD       = 8,
   parameter int unsigned BRIGHT_W    = 4,
   parameter bit          SEG_ACT_LOW = 1'b1,
   parameter bit          DIG_ACT_LOW = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [$clog2(DIGITS)-1:0]  wr_addr,
   input  logic [3:0]                 wr_data,
   input  logic                       wr_dp,
   input  logic                       wr_commit,
   input  logic [BRIGHT_W-1:0]        bright,
   input  logic                       blank_lz,
`ifdef DISP_LAMP_TEST_EN
   input  logic                       lamp_test,
`endif
   output logic [SEG_W-1:0]           dout,
   output logic [DIGITS-1:0]          dnum,
   output logic                       frame_tick
);

   localparam int unsigned AW = $clog2(DIGITS);
   localparam int unsigned PW = $clog2(SCAN_DIV);

   digit_t              r_shadow [DIGITS];
   digit_t              r_active [DIGITS];
   logic                r_pending;
   logic                w_pending_d;
   logic [PW-1:0]       r_presc;
   logic [AW-1:0]       r_idx;
   logic [BRIGHT_W-1:0] r_pwm;
   logic [SEG_W-1:0]    r_dout;
   logic [SEG_W-1:0]    w_dout_d;
   logic [SEG_W-1:0]    w_seg;
   logic [DIGITS-1:0]   r_dnum;
   logic [DIGITS-1:0]   w_dnum_d;
   logic [DIGITS-1:0]   w_blank;
   logic                w_wrap;
   logic                w_frame_end;
   logic                w_wr_fire;
   logic                w_pwm_on;
   digit_t              w_cur;

   assign wr_ready    = ~r_pending;
   assign w_wr_fire   = wr_valid & ~r_pending;
   assign w_wrap      = (r_presc == PW'(SCAN_DIV - 1));
   assign w_frame_end = w_wrap && (r_idx == AW'(DIGITS - 1));
   assign frame_tick  = w_frame_end;
   assign w_cur       = r_active[r_idx];
   assign w_pwm_on    = (bright == '1) || (r_pwm < bright);
   assign dout        = r_dout;
   assign dnum        = r_dnum;

   // Banks: writes only reach the shadow; the active bank changes only at a committed frame end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DIGITS; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         if (w_wr_fire && (32'(wr_addr) < DIGITS)) begin
            r_shadow[wr_addr] <= '{dp: wr_dp, val: wr_data};
         end
         if (w_frame_end && r_pending) begin
            for (int i = 0; i < DIGITS; i++) begin
               r_active[i] <= r_shadow[i];
            end
         end
      end
   end

   // A commit seen on the frame-end cycle itself re-arms pending for the next frame end.
   always_comb begin
      w_pending_d = r_pending;
      if (w_frame_end && r_pending) begin
         w_pending_d = 1'b0;
      end
      if (wr_commit) begin
         w_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= 1'b0;
         r_presc   <= '0;
         r_idx     <= '0;
         r_pwm     <= '0;
      end else begin
         r_pending <= w_pending_d;
         r_pwm     <= r_pwm + 1'b1;
         if (w_wrap) begin
            r_presc <= '0;
            r_idx   <= (r_idx == AW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   // Walk from the most significant digit down; blanking stops at the first non-blank digit.
   always_comb begin
      logic v_lead;
      w_blank = '0;
      v_lead  = blank_lz;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_blank[i] = v_lead && (r_active[i] == '0);
         v_lead     = w_blank[i];
      end
   end

   hex7seg_m #(
      .SEG_W (SEG_W)
   ) u_hex7seg (
      .i_val (w_cur.val),
      .i_dp  (w_cur.dp),
      .o_seg (w_seg)
   );

   always_comb begin
      w_dout_d = w_seg;
      if (!w_pwm_on || w_blank[r_idx]) begin
         w_dout_d = '0;
      end
      w_dnum_d = '0;
      if (r_presc >= PW'(GUARD)) begin
         w_dnum_d[r_idx] = 1'b1;
      end
`ifdef DISP_LAMP_TEST_EN
      if (lamp_test) begin
         w_dout_d        = '1;
         w_dnum_d        = '0;
         w_dnum_d[r_idx] = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout <= SEG_W'(apply_pol('0, SEG_ACT_LOW));
         r_dnum <= DIGITS'(apply_pol('0, DIG_ACT_LOW));
      end else begin
         r_dout <= SEG_W'(apply_pol(32'(w_dout_d), SEG_ACT_LOW));
         r_dnum <= DIGITS'(apply_pol(32'(w_dnum_d), DIG_ACT_LOW));
      end
   end

endmodule

// File: tb/tb_disp_scan_m.sv
// Self-checking bench for disp_scan_m: scoreboard of expected per-slot outputs plus window counts.
module tb_disp_scan_m;

   typedef struct packed {
      logic [7:0] dout;
      logic [3:0] dnum;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_valid, wr_ready, wr_dp, wr_commit, blank_lz, frame_tick;
   logic [1:0] wr_addr;
   logic [3:0] wr_data, bright, dnum;
   logic [7:0] dout;
   logic       wr_valid6, wr_ready6, wr_dp6, wr_commit6, tick6;
   logic [2:0] wr_addr6;
   logic [3:0] wr_data6;
   logic [5:0] dnum6;
   logic [7:0] dout6;
`ifdef DISP_LAMP_TEST_EN
   logic       lamp_test;
`endif

   exp_t q_exp[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   disp_scan_m #(
      .DIGITS(4), .SEG_W(8), .SCAN_DIV(16), .GUARD(2), .BRIGHT_W(4),
      .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp), .wr_commit(wr_commit),
      .bright(bright), .blank_lz(blank_lz),
`ifdef DISP_LAMP_TEST_EN
      .lamp_test(lamp_test),
`endif
      .dout(dout), .dnum(dnum), .frame_tick(frame_tick)
   );

   // Six digits so that out-of-range addresses are representable on the write port.
   disp_scan_m #(
      .DIGITS(6), .SEG_W(8), .SCAN_DIV(16), .GUARD(2), .BRIGHT_W(4),
      .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
   ) u_dut6 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid6), .wr_ready(wr_ready6),
      .wr_addr(wr_addr6), .wr_data(wr_data6), .wr_dp(wr_dp6), .wr_commit(wr_commit6),
      .bright(bright), .blank_lz(blank_lz),
`ifdef DISP_LAMP_TEST_EN
      .lamp_test(lamp_test),
`endif
      .dout(dout6), .dnum(dnum6), .frame_tick(tick6)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // digs = {d3, d2, d1, d0}, each {dp, val}; pushes one expected entry per slot 0..3.
   task automatic push_frame(input logic [19:0] digs, input logic lz);
      logic [4:0] d [4];
      logic [3:0] blank;
      logic       lead;
      exp_t       e;
      for (int k = 0; k < 4; k++) d[k] = digs[k*5 +: 5];
      blank = '0;
      lead  = lz;
      for (int k = 3; k >= 1; k--) begin
         blank[k] = lead && (d[k] == 5'd0);
         lead     = blank[k];
      end
      for (int k = 0; k < 4; k++) begin
         e.dout = blank[k] ? 8'hFF : ~{d[k][4], seg7(d[k][3:0])};
         e.dnum = ~(4'b0001 << k);
         q_exp.push_back(e);
      end
   endtask

   // Called at the negedge where frame_tick was seen, minus (8 - skip) negedges already spent.
   task automatic capture(input int skip);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         repeat ((k == 0) ? skip : 16) @(negedge clk);
         e = q_exp.pop_front();
         check_eq($sformatf("slot%0d_dout", k), 32'(dout), 32'(e.dout));
         check_eq($sformatf("slot%0d_dnum", k), 32'(dnum), 32'(e.dnum));
      end
   endtask

   task automatic wait_tick(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!frame_tick && cycles < 200);
      check_eq("tick_seen", 32'(frame_tick), 32'd1);
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic dp, input logic c);
      wr_addr   = a;
      wr_data   = d;
      wr_dp     = dp;
      wr_valid  = 1'b1;
      wr_commit = c;
      check_eq("wr_ready", 32'(wr_ready), 32'd1);
      @(negedge clk);
      wr_valid  = 1'b0;
      wr_commit = 1'b0;
   endtask

   task automatic pulse_commit();
      wr_commit = 1'b1;
      @(negedge clk);
      wr_commit = 1'b0;
   endtask

   initial begin
      int cyc, bad, on, n;
      rst_n = 1'b0;
      wr_valid = 0; wr_addr = 0; wr_data = 0; wr_dp = 0; wr_commit = 0;
      wr_valid6 = 0; wr_addr6 = 0; wr_data6 = 0; wr_dp6 = 0; wr_commit6 = 0;
      bright = 4'hF; blank_lz = 1'b0;
`ifdef DISP_LAMP_TEST_EN
      lamp_test = 1'b0;
`endif
      #12;
      check_eq("rst_dout", 32'(dout), 32'hFF);
      check_eq("rst_dnum", 32'(dnum), 32'hF);
      check_eq("rst_tick", 32'(frame_tick), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      check_eq("rst_ready", 32'(wr_ready), 32'd1);

      // Asynchronous reset in the middle of a frame.
      repeat (37) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_eq("async_dout", 32'(dout), 32'hFF);
      check_eq("async_dnum", 32'(dnum), 32'hF);
      @(negedge clk) rst_n = 1'b1;
      check_eq("async_ready", 32'(wr_ready), 32'd1);

      // Out-of-range addresses are acknowledged but leave the bank untouched.
      wr_valid6 = 1'b1; wr_addr6 = 3'd6; wr_data6 = 4'h5;
      check_eq("oor_ready6", 32'(wr_ready6), 32'd1);
      @(negedge clk) wr_addr6 = 3'd7; wr_data6 = 4'h9; wr_dp6 = 1'b1;
      check_eq("oor_ready7", 32'(wr_ready6), 32'd1);
      @(negedge clk) wr_valid6 = 1'b0; wr_commit6 = 1'b1;
      @(negedge clk) wr_commit6 = 1'b0;
      repeat (300) @(negedge clk);
      bad = 0; on = 0;
      for (int i = 0; i < 96; i++) begin
         @(negedge clk);
         if (dnum6 != 6'h3F && dout6 != 8'hC0) bad++;
         if (tick6) on++;
      end
      check_eq("oor_bank", 32'(bad), 32'd0);
      check_eq("oor_ticks", 32'(on), 32'd1);
      check_eq("oor_ready_back", 32'(wr_ready6), 32'd1);

      // Frame period and tick width.
      wait_tick(cyc);
      wait_tick(cyc);
      check_eq("frame_period", 32'(cyc), 32'd64);
      @(negedge clk);
      check_eq("tick_width", 32'(frame_tick), 32'd0);

      // Write "1234" and commit; the old (all-zero) bank stays on until the frame end.
      wait_tick(cyc);
      wr(2'd3, 4'h1, 1'b0, 1'b0);
      wr(2'd2, 4'h2, 1'b0, 1'b0);
      wr(2'd1, 4'h3, 1'b0, 1'b0);
      wr(2'd0, 4'h4, 1'b0, 1'b0);
      pulse_commit();
      check_eq("pend_ready", 32'(wr_ready), 32'd0);
      bad = 0; n = 0;
      while (!frame_tick && n < 200) begin
         if (dnum != 4'hF && dout != 8'hC0) bad++;
         if (wr_ready) bad++;
         @(negedge clk);
         n++;
      end
      check_eq("tick_seen", 32'(frame_tick), 32'd1);
      check_eq("stale_bank", 32'(bad), 32'd0);
      push_frame({5'h01, 5'h02, 5'h03, 5'h04}, 1'b0);
      capture(8);
      check_eq("ready_back", 32'(wr_ready), 32'd1);

      // Leading-zero blanking on "0050".
      blank_lz = 1'b1;
      wait_tick(cyc);
      wr(2'd3, 4'h0, 1'b0, 1'b0);
      wr(2'd2, 4'h0, 1'b0, 1'b0);
      wr(2'd1, 4'h5, 1'b0, 1'b0);
      wr(2'd0, 4'h0, 1'b0, 1'b0);
      pulse_commit();
      wait_tick(cyc);
      push_frame({5'h00, 5'h00, 5'h05, 5'h00}, 1'b1);
      capture(8);
      blank_lz = 1'b0;
      wait_tick(cyc);
      push_frame({5'h00, 5'h00, 5'h05, 5'h00}, 1'b0);
      capture(8);

      // Brightness 4/16: lit during the first four PWM counts of every slot.
      bright = 4'd4;
      wait_tick(cyc);
      bad = 0; on = 0;
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         if (dout != 8'hFF) on++;
         if ((dout != 8'hFF) != (((i + 14) % 16) < 4)) bad++;
      end
      check_eq("pwm4_on", 32'(on), 32'd16);
      check_eq("pwm4_phase", 32'(bad), 32'd0);

      // Brightness 0 and the guard interval at the start of each slot.
      bright = 4'd0;
      wait_tick(cyc);
      bad = 0; on = 0;
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         if (dout != 8'hFF) on++;
         if ((dnum == 4'hF) != (((i + 14) % 16) < 2)) bad++;
      end
      check_eq("pwm0_dark", 32'(on), 32'd0);
      check_eq("guard", 32'(bad), 32'd0);
      bright = 4'hF;

      // Commit on the frame-end cycle lands one frame later.
      wait_tick(cyc);
      wr(2'd3, 4'h9, 1'b0, 1'b0);
      wr(2'd2, 4'h8, 1'b0, 1'b0);
      wr(2'd1, 4'h7, 1'b1, 1'b0);
      wr(2'd0, 4'h6, 1'b0, 1'b0);
      wait_tick(cyc);
      pulse_commit();
      check_eq("fe_pend_ready", 32'(wr_ready), 32'd0);
      push_frame({5'h00, 5'h00, 5'h05, 5'h00}, 1'b0);
      capture(7);
      wait_tick(cyc);
      push_frame({5'h09, 5'h08, 5'h17, 5'h06}, 1'b0);
      capture(8);

      // Write and commit in the same cycle: the write is part of the committed bank.
      wr(2'd0, 4'hA, 1'b0, 1'b1);
      wait_tick(cyc);
      push_frame({5'h09, 5'h08, 5'h17, 5'h0A}, 1'b0);
      capture(8);
      check_eq("wc_ready", 32'(wr_ready), 32'd1);

`ifdef DISP_LAMP_TEST_EN
      lamp_test = 1'b1;
      bright    = 4'd0;
      wait_tick(cyc);
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (dout != 8'h00 || dnum == 4'hF) bad++;
      end
      check_eq("lamp_test", 32'(bad), 32'd0);
      lamp_test = 1'b0;
      bright    = 4'hF;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
